// File: rtl/pipe_hazard_control_pkg.sv
// pipe_hazard_control_pkg: shared pipeline types for the hazard controller.
package pipe_hazard_control_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

endpackage

// File: rtl/pipe_hazard_control_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_control.sv
// pipe_hazard_control: stall/flush/redirect control for the 5-stage pipeline,
// with data-memory wait tracking, timeout detection and perf counters.
module pipe_hazard_control
    import pipe_hazard_control_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic             UsesRt_D,
    input  logic             MemRead_E,
    input  logic [4:0]       WriteReg_E,
    input  logic             BranchEQ_M,
    input  logic             BranchNE_M,
    input  logic             Zero_M,
    input  logic [1:0]       Jump_M,
    input  logic             MemRead_M,
    input  logic             MemWrite_M,
    input  logic [31:0]      BranchAdderResult_M,
    input  logic [31:0]      JumpAddress_M,
    input  logic [31:0]      ReadData1_M,
    input  logic             MemReady,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_M,
    output logic             Flush_W,
    output logic             PCSrc,
    output logic [31:0]      RedirectPC,
    output logic             Error,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int            WW        = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT);

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic          taken, redirect, luse, mem_pend;
    logic          run_row, hold, luse_stall, pc_src;
    logic [31:0]   target;

    always_comb begin
        taken    = (BranchEQ_M && Zero_M) || (BranchNE_M && !Zero_M);
        redirect = (Jump_M == JMP_J) || (Jump_M == JMP_JR) || taken;
        target   = (Jump_M == JMP_J)  ? JumpAddress_M :
                   (Jump_M == JMP_JR) ? ReadData1_M   : BranchAdderResult_M;
        luse     = MemRead_E && (WriteReg_E != 5'd0) &&
                   ((WriteReg_E == Rs_D) || (UsesRt_D && (WriteReg_E == Rt_D)));
        mem_pend = (MemRead_M || MemWrite_M) && !MemReady;
    end

    // run_row: the normal priority evaluation (redirect > mem wait > load-use) applies this cycle
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        run_row  = 1'b0;
        hold     = 1'b0;
        case (state)
            RUN: run_row = 1'b1;
            MEMWAIT: begin
                if (MemReady) begin
                    run_row  = 1'b1;
                    state_nx = RUN;
                    wait_nx  = '0;
                end else begin
                    hold     = 1'b1;
                    wait_nx  = wait_cnt + 1'b1;
                    state_nx = (wait_nx == WAIT_LAST) ? ERROR : MEMWAIT;
                end
            end
            ERROR: hold = 1'b1;
            default: state_nx = RUN;
        endcase
        pc_src     = run_row && redirect;
        luse_stall = run_row && !redirect && !mem_pend && luse;
        if (run_row && !redirect && mem_pend) begin
            hold     = 1'b1;
            wait_nx  = WAIT_ONE;
            state_nx = (WAIT_ONE == WAIT_LAST) ? ERROR : MEMWAIT;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    // every control is forced low while reset is held, regardless of inputs
    assign Stall_F    = reset && (hold || luse_stall);
    assign Stall_D    = reset && (hold || luse_stall);
    assign Stall_E    = reset && hold;
    assign Stall_M    = reset && hold;
    assign Flush_D    = reset && pc_src;
    assign Flush_E    = reset && (pc_src || luse_stall);
    assign Flush_M    = reset && pc_src;
    assign Flush_W    = reset && hold;
    assign PCSrc      = reset && pc_src;
    assign RedirectPC = PCSrc ? target : 32'd0;
    assign Error      = reset && (state == ERROR);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (Stall_F),
        .count (StallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (PCSrc),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_pipe_hazard_control.sv
// tb_pipe_hazard_control: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_control;

    localparam int MW  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    // {Stall_F,Stall_D,Stall_E,Stall_M,Flush_D,Flush_E,Flush_M,Flush_W,PCSrc,Error}
    localparam logic [9:0] P_NONE  = 10'b0000000000;
    localparam logic [9:0] P_LUSE  = 10'b1100010000;
    localparam logic [9:0] P_REDIR = 10'b0000111010;
    localparam logic [9:0] P_HOLD  = 10'b1111000100;
    localparam logic [9:0] P_ERR   = 10'b1111000101;

    logic        clk = 1'b1;
    logic        reset = 1'b0;
    logic [4:0]  Rs_D, Rt_D, WriteReg_E;
    logic        UsesRt_D, MemRead_E, BranchEQ_M, BranchNE_M, Zero_M;
    logic [1:0]  Jump_M;
    logic        MemRead_M, MemWrite_M, MemReady;
    logic [31:0] BranchAdderResult_M, JumpAddress_M, ReadData1_M;
    logic        Stall_F, Stall_D, Stall_E, Stall_M;
    logic        Flush_D, Flush_E, Flush_M, Flush_W, PCSrc, Error;
    logic [31:0] RedirectPC;
    logic [CW-1:0] StallCount, FlushCount;
    logic [9:0]  ctl;

    int checks = 0;
    int failures = 0;

    bit          m_err;
    int          m_waits, m_stalls, m_flushes;
    logic [9:0]  exp_ctl;
    logic [31:0] exp_rpc;
    bit          exp_enter;

    assign ctl = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_M, Flush_W, PCSrc, Error};

    always #5 clk = ~clk;

    pipe_hazard_control #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Rs_D(Rs_D), .Rt_D(Rt_D), .UsesRt_D(UsesRt_D),
        .MemRead_E(MemRead_E), .WriteReg_E(WriteReg_E), .BranchEQ_M(BranchEQ_M),
        .BranchNE_M(BranchNE_M), .Zero_M(Zero_M), .Jump_M(Jump_M), .MemRead_M(MemRead_M),
        .MemWrite_M(MemWrite_M), .BranchAdderResult_M(BranchAdderResult_M),
        .JumpAddress_M(JumpAddress_M), .ReadData1_M(ReadData1_M), .MemReady(MemReady),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M), .Flush_W(Flush_W),
        .PCSrc(PCSrc), .RedirectPC(RedirectPC), .Error(Error),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    task automatic clear_inputs;
        Rs_D = 0; Rt_D = 0; UsesRt_D = 0; MemRead_E = 0; WriteReg_E = 0;
        BranchEQ_M = 0; BranchNE_M = 0; Zero_M = 0; Jump_M = 0;
        MemRead_M = 0; MemWrite_M = 0; MemReady = 0;
        BranchAdderResult_M = 0; JumpAddress_M = 0; ReadData1_M = 0;
    endtask

    task automatic model_reset;
        m_err = 0; m_waits = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // expected controls for the current cycle from the hazard rules
    task automatic model_eval;
        bit tk, rd, lu, mp;
        logic [31:0] tg;
        tk = (BranchEQ_M && Zero_M) || (BranchNE_M && !Zero_M);
        rd = (Jump_M == 2'b01) || (Jump_M == 2'b10) || tk;
        tg = (Jump_M == 2'b01) ? JumpAddress_M : (Jump_M == 2'b10) ? ReadData1_M : BranchAdderResult_M;
        lu = MemRead_E && (WriteReg_E != 0) && ((WriteReg_E == Rs_D) || (UsesRt_D && WriteReg_E == Rt_D));
        mp = (MemRead_M || MemWrite_M) && !MemReady;
        exp_rpc = 0;
        exp_enter = 0;
        if (!reset) exp_ctl = P_NONE;
        else if (m_err) exp_ctl = P_ERR;
        else if (m_waits > 0 && !MemReady) exp_ctl = P_HOLD;
        else if (rd) begin exp_ctl = P_REDIR; exp_rpc = tg; end
        else if (mp) begin exp_ctl = P_HOLD; exp_enter = 1; end
        else if (lu) exp_ctl = P_LUSE;
        else exp_ctl = P_NONE;
    endtask

    task automatic tick;
        model_eval();
        @(negedge clk);
        if (reset) begin
            if (exp_ctl[9]) m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
            if (exp_ctl[1]) m_flushes = (m_flushes < SAT) ? m_flushes + 1 : SAT;
            if (m_err) ;
            else if (exp_enter) begin m_waits = 1; m_err = (MW == 1); end
            else if (m_waits > 0 && !MemReady) begin m_waits++; if (m_waits == MW) m_err = 1; end
            else m_waits = 0;
        end
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        Jump_M = 2'b01; JumpAddress_M = 32'h00400444; MemRead_E = 1; WriteReg_E = 3; Rs_D = 3;
        #1;
        checks++; if (ctl !== P_NONE) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, P_NONE); end
        checks++; if (RedirectPC !== 32'd0) begin failures++; $display("FAIL reset_rpc got=%h exp=0", RedirectPC); end
        checks++; if (StallCount !== 0 || FlushCount !== 0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", StallCount, FlushCount); end
        clear_inputs();
        do_reset();
        #1;
        checks++; if (ctl !== P_NONE) begin failures++; $display("FAIL reset_release got=%b exp=%b", ctl, P_NONE); end
    endtask

    task automatic test_load_use;
        do_reset(); clear_inputs();
        MemRead_E = 1; WriteReg_E = 8; Rs_D = 8;
        #1;
        checks++; if (ctl !== P_LUSE) begin failures++; $display("FAIL luse_ctl got=%b exp=%b", ctl, P_LUSE); end
        tick();
        checks++; if (StallCount !== 1) begin failures++; $display("FAIL luse_cnt got=%0d exp=1", StallCount); end
        MemRead_E = 0; MemRead_M = 1; MemReady = 1; Rs_D = 3;
        #1;
        checks++; if (ctl !== P_NONE) begin failures++; $display("FAIL luse_one_cycle got=%b exp=%b", ctl, P_NONE); end
        tick();
        MemRead_M = 0; MemRead_E = 1; WriteReg_E = 0; Rs_D = 0;
        #1;
        checks++; if (ctl !== P_NONE) begin failures++; $display("FAIL luse_r0 got=%b exp=%b", ctl, P_NONE); end
        WriteReg_E = 9; Rt_D = 9; Rs_D = 1; UsesRt_D = 0;
        #1;
        checks++; if (ctl !== P_NONE) begin failures++; $display("FAIL luse_rt_unused got=%b exp=%b", ctl, P_NONE); end
        UsesRt_D = 1;
        #1;
        checks++; if (ctl !== P_LUSE) begin failures++; $display("FAIL luse_rt got=%b exp=%b", ctl, P_LUSE); end
        tick();
        checks++; if (StallCount !== 2) begin failures++; $display("FAIL luse_cnt2 got=%0d exp=2", StallCount); end
    endtask

    task automatic test_branch;
        do_reset(); clear_inputs();
        BranchEQ_M = 1; Zero_M = 1; BranchAdderResult_M = 32'h00400020;
        #1;
        checks++; if (ctl !== P_REDIR) begin failures++; $display("FAIL beq_ctl got=%b exp=%b", ctl, P_REDIR); end
        checks++; if (RedirectPC !== 32'h00400020) begin failures++; $display("FAIL beq_rpc got=%h exp=00400020", RedirectPC); end
        tick();
        checks++; if (FlushCount !== 1 || StallCount !== 0) begin failures++; $display("FAIL beq_cnt got=%0d/%0d exp=1/0", FlushCount, StallCount); end
        Zero_M = 0;
        #1;
        checks++; if (ctl !== P_NONE || RedirectPC !== 0) begin failures++; $display("FAIL beq_nt got=%b/%h exp=%b/0", ctl, RedirectPC, P_NONE); end
        BranchEQ_M = 0; BranchNE_M = 1;
        #1;
        checks++; if (ctl !== P_REDIR || RedirectPC !== 32'h00400020) begin failures++; $display("FAIL bne_taken got=%b/%h exp=%b/00400020", ctl, RedirectPC, P_REDIR); end
        BranchNE_M = 0; Jump_M = 2'b11; JumpAddress_M = 32'h00400abc;
        #1;
        checks++; if (ctl !== P_NONE || RedirectPC !== 0) begin failures++; $display("FAIL jump11_none got=%b/%h exp=%b/0", ctl, RedirectPC, P_NONE); end
        Jump_M = 2'b01; BranchNE_M = 1;
        #1;
        checks++; if (RedirectPC !== 32'h00400abc) begin failures++; $display("FAIL jump_priority got=%h exp=00400abc", RedirectPC); end
        tick();
        checks++; if (FlushCount !== 2) begin failures++; $display("FAIL jump_cnt got=%0d exp=2", FlushCount); end
    endtask

    task automatic test_redirect_vs_luse;
        do_reset(); clear_inputs();
        Jump_M = 2'b10; ReadData1_M = 32'h00400100; MemRead_E = 1; WriteReg_E = 5; Rs_D = 5;
        #1;
        checks++; if (ctl !== P_REDIR) begin failures++; $display("FAIL redir_luse_ctl got=%b exp=%b", ctl, P_REDIR); end
        checks++; if (RedirectPC !== 32'h00400100) begin failures++; $display("FAIL redir_luse_rpc got=%h exp=00400100", RedirectPC); end
        tick();
        checks++; if (StallCount !== 0 || FlushCount !== 1) begin failures++; $display("FAIL redir_luse_cnt got=%0d/%0d exp=0/1", StallCount, FlushCount); end
    endtask

    task automatic test_mem_wait;
        do_reset(); clear_inputs();
        MemWrite_M = 1; MemReady = 1;
        #1;
        checks++; if (ctl !== P_NONE) begin failures++; $display("FAIL zero_wait got=%b exp=%b", ctl, P_NONE); end
        tick();
        MemWrite_M = 0; MemRead_M = 1; MemReady = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== P_HOLD) begin failures++; $display("FAIL mem_hold%0d got=%b exp=%b", i, ctl, P_HOLD); end
            tick();
        end
        MemReady = 1;
        #1;
        checks++; if (ctl !== P_NONE) begin failures++; $display("FAIL mem_release got=%b exp=%b", ctl, P_NONE); end
        tick();
        checks++; if (StallCount !== 3) begin failures++; $display("FAIL mem_cnt got=%0d exp=3", StallCount); end
        MemRead_M = 0; MemReady = 0;
        #1;
        checks++; if (ctl !== P_NONE) begin failures++; $display("FAIL mem_back_run got=%b exp=%b", ctl, P_NONE); end
    endtask

    task automatic test_timeout;
        do_reset(); clear_inputs();
        MemRead_M = 1; MemReady = 0;
        for (int i = 1; i <= MW; i++) begin
            tick();
            checks++;
            if (Error !== (i == MW)) begin failures++; $display("FAIL timeout_err%0d got=%b exp=%b", i, Error, i == MW); end
        end
        MemRead_M = 0; MemReady = 1;
        #1;
        checks++; if (ctl !== P_ERR) begin failures++; $display("FAIL err_sticky got=%b exp=%b", ctl, P_ERR); end
        tick();
        checks++; if (ctl !== P_ERR || StallCount !== 5) begin failures++; $display("FAIL err_hold got=%b/%0d exp=%b/5", ctl, StallCount, P_ERR); end
    endtask

    task automatic test_reset_mid_wait;
        do_reset(); clear_inputs();
        MemRead_M = 1; MemReady = 0;
        tick();
        tick();
        checks++; if (StallCount !== 2) begin failures++; $display("FAIL midwait_cnt got=%0d exp=2", StallCount); end
        #2;
        reset = 1'b0;
        model_reset();
        Jump_M = 2'b01; JumpAddress_M = 32'h00400800;
        #1;
        checks++; if (ctl !== P_NONE || RedirectPC !== 0) begin failures++; $display("FAIL async_reset_ctl got=%b/%h exp=%b/0", ctl, RedirectPC, P_NONE); end
        checks++; if (StallCount !== 0 || FlushCount !== 0) begin failures++; $display("FAIL async_reset_cnt got=%0d/%0d exp=0/0", StallCount, FlushCount); end
        @(negedge clk);
        #1;
        reset = 1'b1;
        clear_inputs();
        #1;
        checks++; if (ctl !== P_NONE) begin failures++; $display("FAIL run_after_reset got=%b exp=%b", ctl, P_NONE); end
    endtask

    task automatic test_saturation;
        do_reset(); clear_inputs();
        MemRead_E = 1; WriteReg_E = 4; Rs_D = 4;
        repeat (20) tick();
        checks++; if (StallCount !== CW'(SAT)) begin failures++; $display("FAIL stall_sat got=%0d exp=%0d", StallCount, SAT); end
        clear_inputs();
        BranchEQ_M = 1; Zero_M = 1;
        repeat (20) tick();
        checks++; if (FlushCount !== CW'(SAT) || StallCount !== CW'(SAT)) begin failures++; $display("FAIL flush_sat got=%0d/%0d exp=%0d/%0d", FlushCount, StallCount, SAT, SAT); end
    endtask

    task automatic test_random;
        do_reset(); clear_inputs();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            Rs_D = 5'($urandom_range(0, 3)); Rt_D = 5'($urandom_range(0, 3));
            WriteReg_E = 5'($urandom_range(0, 3)); UsesRt_D = 1'($urandom); MemRead_E = 1'($urandom);
            BranchEQ_M = ($urandom_range(0, 5) == 0); BranchNE_M = ($urandom_range(0, 5) == 0);
            Zero_M = 1'($urandom);
            Jump_M = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            MemRead_M = ($urandom_range(0, 3) == 1); MemWrite_M = ($urandom_range(0, 3) == 2);
            MemReady = 1'($urandom);
            BranchAdderResult_M = $urandom; JumpAddress_M = $urandom; ReadData1_M = $urandom;
            #1;
            model_eval();
            checks++; if (ctl !== exp_ctl || RedirectPC !== exp_rpc) begin failures++; $display("FAIL rand_ctl[%0d] got=%b/%h exp=%b/%h", n, ctl, RedirectPC, exp_ctl, exp_rpc); end
            tick();
            checks++;
            if (StallCount !== CW'(m_stalls) || FlushCount !== CW'(m_flushes) || Error !== m_err) begin
                failures++;
                $display("FAIL rand_state[%0d] got=%0d/%0d/%b exp=%0d/%0d/%b", n, StallCount, FlushCount, Error, m_stalls, m_flushes, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_redirect_vs_luse();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_control.md
# pipe_hazard_control

Central hazard controller for the 5-stage pipeline. It consumes the decode-stage operands and the control and data fields held in the ID/EX and EX/MEM pipeline registers. It drives stall and flush controls back into every pipeline register and produces the PC redirect. It resolves load-use hazards, branches and jumps resolved in MEM, and multi-cycle data-memory waits, and it keeps saturating stall and flush performance counters.

## Interface
Parameters:
- MAX_WAIT, 15: data-memory wait cycles before a fatal timeout.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1: pipeline clock. All state updates on negedge clk, the same edge the pipeline registers capture on.
- reset  in  1: asynchronous, active-low reset.
- Rs_D, Rt_D  in  5 each: source registers of the instruction in ID.
- UsesRt_D  in  1: the ID instruction reads Rt.
- MemRead_E  in  1: ID/EX control field.
- WriteReg_E  in  5: ID/EX field.
- BranchEQ_M, BranchNE_M, Zero_M  in  1 each: EX/MEM fields.
- Jump_M  in  2: EX/MEM field. Encoding: 00 none, 01 j/jal, 10 jr, 11 treated as none.
- MemRead_M, MemWrite_M  in  1 each: EX/MEM fields.
- BranchAdderResult_M, JumpAddress_M, ReadData1_M  in  32 each: EX/MEM fields.
- MemReady  in  1: data memory has completed the access in MEM this cycle.
- Stall_F, Stall_D, Stall_E, Stall_M  out  1 each: hold PC, IF/ID, ID/EX, EX/MEM respectively.
- Flush_D, Flush_E, Flush_M, Flush_W  out  1 each: zero the control bits captured into IF/ID, ID/EX, EX/MEM, MEM/WB respectively.
- PCSrc  out  1: redirect valid this cycle.
- RedirectPC  out  32: redirect target.
- Error  out  1: sticky memory-timeout flag.
- StallCount, FlushCount  out  CNT_W each: saturating counters.

## Operation
- Taken condition: taken = (BranchEQ_M & Zero_M) | (BranchNE_M & ~Zero_M).
- Redirect target:
  - Jump_M=01 → JumpAddress_M.
  - Jump_M=10 → ReadData1_M.
  - Otherwise, if taken → BranchAdderResult_M.
  - Jump has priority over branch.
- Load-use hazard: luse = MemRead_E & (WriteReg_E≠0) & (WriteReg_E==Rs_D | (UsesRt_D & WriteReg_E==Rt_D)).
- Memory-pending condition: mem_pend = (MemRead_M | MemWrite_M) & ~MemReady.
- FSM states: RUN, MEMWAIT, ERROR.
- RUN, evaluated in priority order:
  1. Redirect (jump or taken): PCSrc=1; Flush_D=Flush_E=Flush_M=1. The MEM instruction itself proceeds to WB, so jal still writes.
  2. Else mem_pend: Stall_F/D/E/M=1, Flush_W=1. Next state MEMWAIT, wait counter←1.
  3. Else luse: Stall_F=Stall_D=1, Flush_E=1, which inserts one bubble.
  4. Else all controls 0.
- MEMWAIT:
  - If MemReady=1: all stalls released this cycle, RUN-row evaluation applies, next state RUN.
  - Else: four stalls plus Flush_W. Wait counter +1. When the counter reaches MAX_WAIT, next state ERROR.
- ERROR: Stall_F/D/E/M=1, Flush_W=1, Error=1. Held until reset.
- Counters:
  - StallCount increments on every edge with Stall_F=1.
  - FlushCount increments on every edge with PCSrc=1.
  - Both saturate at all-ones.
- Whenever PCSrc=0, RedirectPC=0.

## Timing
- Control outputs are combinational from state and current inputs. They are valid before the negedge at which the pipeline registers and the PC sample them.
- A load-use stall lasts exactly 1 cycle. On the following edge the load has moved to MEM and luse deasserts.
- Redirect takes effect at the same edge. There are 3 wrong-path instructions (IF/ID, ID/EX, EX/MEM inputs) and all are flushed.
- A zero-wait memory access (MemReady=1 in the first cycle) costs no stall.
- An N-cycle wait gives N stalled edges and StallCount += N.
- Timeout: ERROR is entered on the edge where the MAX_WAIT-th consecutive wait cycle is counted.
- Reset, asserted at any time including mid-MEMWAIT:
  - Immediately: state RUN, wait counter 0, StallCount=FlushCount=0, Error=0.
  - All stall and flush outputs, PCSrc and RedirectPC are 0 while reset is low.
- Redirect and mem_pend cannot coincide, because a branch or jump never accesses memory. Redirect still wins if both are seen.

## Structure
- Shared pipeline package holds:
  - the state enum (RUN/MEMWAIT/ERROR);
  - the Jump encoding constants (JMP_NONE, JMP_J, JMP_JR).
- One natural sub-module, sat_counter (parameter CNT_W; inputs clk, reset, inc; output count), instantiated for StallCount and FlushCount.

## Test plan
- Load-use hazard: MemRead_E=1, WriteReg_E=8, Rs_D=8 → Stall_F=Stall_D=Flush_E=1 for exactly one cycle, StallCount=1. Repeat with WriteReg_E=0 → no stall.
- Taken BEQ: BranchEQ_M=1, Zero_M=1, BranchAdderResult_M=0x00400020 → PCSrc=1, RedirectPC=0x00400020, Flush_D/E/M=1, FlushCount=1. Repeat with Zero_M=0 → PCSrc=0, RedirectPC=0.
- Redirect beats load-use: Jump_M=10, ReadData1_M=0x00400100, with a load-use hazard in the same cycle → RedirectPC=0x00400100, Stall_F=0, Flush_E=1.
- Memory wait: MemRead_M=1 with MemReady low for 3 cycles then high → Stall_F/D/E/M and Flush_W high for 3 edges, StallCount=3, state back to RUN, no stall on the release cycle.
- Timeout and reset: with MAX_WAIT=4 and MemReady held low → Error=1 after 4 wait edges and stays 1. Assert reset mid-MEMWAIT in a second run → all outputs 0 and counters 0 asynchronously, state RUN after release.
